keypoint_packer: RTL
====================

# keypoint_packer

Frame-aware keypoint result buffer and serializer that sits directly behind the ORB feature chip's keypoint outputs (coordinate, score, flag, descriptor, start/end). It absorbs bursts of keypoints in a record FIFO and emits each one as a fixed-length sequence of OUT_W-bit words over a valid/ready stream, followed by a per-frame trailer word. It is the synthesizable, parametrised successor to the bench-side keypoint capture, adding backpressure, per-frame caps, drop accounting and framing.

## Interface
- COORD_W, 10, width of X and Y coordinates
- SCORE_W, 8, width of keypoint score
- DESC_W, 256, descriptor width; must be a multiple of OUT_W
- OUT_W, 32, output word width; must be >= 32 and >= 2*COORD_W+SCORE_W+1
- DEPTH, 16, record FIFO depth (power of two, >= 2)
- MAX_KP, 1023, maximum keypoints accepted per frame (<= 65535)

- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  frame-start pulse
- i_end  in  1  frame-end pulse
- i_flag  in  1  keypoint valid this cycle
- i_x, i_y  in  COORD_W  keypoint coordinates
- i_score  in  SCORE_W  keypoint score
- i_desc  in  DESC_W  keypoint descriptor
- o_data  out  OUT_W  output word
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts word when o_valid && i_ready
- o_last  out  1  final word of a record or the trailer
- o_overflow  out  1  sticky per frame: a keypoint or trailer was dropped
- o_kp_count  out  16  keypoints accepted in current frame
- o_drop_count  out  15  keypoints dropped in current frame, saturating

## Operation
- in_frame flag: set by i_start, cleared by i_end. i_start also clears o_kp_count, o_drop_count, o_overflow. FIFO contents and pending trailer survive i_start.
- Keypoint accepted when i_flag && (in_frame || i_start) && FIFO not full (sampled before any same-cycle pop) && o_kp_count < MAX_KP. i_flag on the i_end cycle is accepted. i_flag outside a frame is ignored, not counted.
- Rejected in-frame keypoint: not stored, o_drop_count += 1 (saturate 0x7FFF), o_overflow set.
- Record word 0 (header): {1'b0, zero pad, X, Y, score}, score in LSBs. Words 1..DESC_W/OUT_W: descriptor, MSB slice first. o_last on final descriptor word.
- Trailer: on i_end while in_frame, latch {o_drop_count, o_kp_count including the i_end-cycle keypoint} into a single pending slot. i_end while slot occupied: new trailer discarded, o_overflow set.
- Trailer word: {1'b1, zero pad, drop[14:0] at [30:16], count[15:0] at [15:0]}, o_last=1. Sent only when serializer IDLE and FIFO empty.
- Serializer FSM: IDLE -> HDR when FIFO non-empty (pop record into shift register); IDLE -> TRAIL when FIFO empty and trailer pending. HDR --handshake--> DESC (idx=0). DESC --handshake--> idx+1; on last word handshake: HDR with next record if FIFO non-empty, else IDLE (or TRAIL if pending). TRAIL --handshake--> IDLE, slot cleared.
- o_data/o_last stable while o_valid && !i_ready; o_valid never drops without handshake.

## Timing
- Reset: o_valid=0, o_data=0, o_last=0, o_overflow=0, counts=0, FIFO empty, trailer slot empty, FSM IDLE, in_frame=0. Reset mid-record abandons the record; next cycle o_valid=0.
- Latency: i_flag at cycle t into empty packer -> header o_valid at t+2.
- Throughput: with i_ready held high, one word per cycle, no bubble between records (1+DESC_W/OUT_W cycles per record).
- Counts update the cycle after the accepting/rejecting edge.

## Test plan
- Defaults, i_ready=1, i_start then one flag X=0x123,Y=0x045,score=0x7A, desc=0x00..1F byte ramp -> header 0x048C457A at t+2, then 8 descriptor words 0x00010203..0x1C1D1E1F, o_last on 9th word only.
- Same keypoint with i_ready toggling 1-0-0-1 -> each word held stable while stalled, sequence identical, 9 handshakes total.
- i_ready=0, 20 consecutive flags -> 16 stored, o_drop_count=4, o_overflow=1 after 17th flag; releasing ready drains exactly 144 words.
- Frame with 3 keypoints then i_end -> 27 record words then trailer 0x80000003 with o_last; i_start then clears o_kp_count to 0.
- MAX_KP=2, 3 flags, i_end -> 2 records, trailer 0x80010002, o_overflow=1.
- i_rst pulsed during 4th descriptor word -> next cycle o_valid=0, counts 0; following frame with one keypoint emits correct header at t+2.

Source files
------------

// File: rtl/keypoint_packer_if.sv
// Keypoint packer bundle: keypoint input group from the feature chip plus the
// serialized output word stream with its status counters.
interface keypoint_packer_if #(
  parameter int COORD_W = 10,
  parameter int SCORE_W = 8,
  parameter int DESC_W  = 256,
  parameter int OUT_W   = 32
);
  logic               i_start;
  logic               i_end;
  logic               i_flag;
  logic [COORD_W-1:0] i_x;
  logic [COORD_W-1:0] i_y;
  logic [SCORE_W-1:0] i_score;
  logic [DESC_W-1:0]  i_desc;
  logic [OUT_W-1:0]   o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;
  logic               o_overflow;
  logic [15:0]        o_kp_count;
  logic [14:0]        o_drop_count;

  // Source/sink side: drives keypoints and ready, observes the word stream
  modport master (
    output i_start, i_end, i_flag, i_x, i_y, i_score, i_desc, i_ready,
    input  o_data, o_valid, o_last, o_overflow, o_kp_count, o_drop_count
  );

  // Packer side
  modport slave (
    input  i_start, i_end, i_flag, i_x, i_y, i_score, i_desc, i_ready,
    output o_data, o_valid, o_last, o_overflow, o_kp_count, o_drop_count
  );
endinterface

// File: rtl/keypoint_packer.sv
// keypoint_packer: buffers keypoints in a record FIFO and serializes each as a
// header word followed by descriptor words (MSB slice first), then emits one
// trailer word per frame carrying the accepted and dropped keypoint counts.
module keypoint_packer #(
  parameter int COORD_W = 10,
  parameter int SCORE_W = 8,
  parameter int DESC_W  = 256,
  parameter int OUT_W   = 32,
  parameter int DEPTH   = 16,
  parameter int MAX_KP  = 1023
) (
  input logic              i_clk,
  input logic              i_rst,
  keypoint_packer_if.slave kp
);
  localparam int NW    = DESC_W / OUT_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int HDR_W = 2 * COORD_W + SCORE_W;
  localparam int REC_W = HDR_W + DESC_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [15:0] MAX_KP_W = 16'(MAX_KP);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DESC, S_TRAIL} state_t;

  // Record storage; the head entry is retired only after its last word is
  // accepted, so the in-flight record still occupies a slot.
  logic [REC_W-1:0] fifo_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [AW:0]      fifo_cnt_q, fifo_cnt_d;
  logic             in_frame_q, in_frame_d;
  logic [15:0]      kp_cnt_q, kp_cnt_d, kp_base;
  logic [14:0]      drop_cnt_q, drop_cnt_d, drop_base;
  logic             ovf_q, ovf_d;
  logic             trail_pend_q, trail_pend_d;
  logic [15:0]      trail_kp_q, trail_kp_d;
  logic [14:0]      trail_drop_q, trail_drop_d;
  state_t           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [DESC_W-1:0] desc_q, desc_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             frame_act, push, reject, pop, hs, trail_clr, trail_free;
  logic [REC_W-1:0] head_rec, next_rec;
  logic [OUT_W-1:0] trail_word;

  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  assign head_rec   = fifo_mem[rd_ptr_q];
  assign next_rec   = fifo_mem[rd_ptr_nxt];

  function automatic logic [OUT_W-1:0] make_hdr(input logic [REC_W-1:0] rec);
    logic [OUT_W-1:0] w;
    w = '0;
    w[HDR_W-1:0] = rec[REC_W-1 -: HDR_W];
    return w;
  endfunction

  // Trailer word: marker bit on top, drop count in [30:16], kp count in [15:0]
  always_comb begin
    trail_word = '0;
    trail_word[OUT_W-1] = 1'b1;
    trail_word[30:16]   = trail_drop_q;
    trail_word[15:0]    = trail_kp_q;
  end

  // Next-state logic: frame counters, FIFO bookkeeping, trailer slot, serializer
  always_comb begin
    frame_act  = kp.i_start | in_frame_q;
    kp_base    = kp.i_start ? 16'd0 : kp_cnt_q;
    drop_base  = kp.i_start ? 15'd0 : drop_cnt_q;
    push       = kp.i_flag && frame_act && (fifo_cnt_q != FULL_CNT) && (kp_base < MAX_KP_W);
    reject     = kp.i_flag && frame_act && !push;
    kp_cnt_d   = push ? kp_base + 16'd1 : kp_base;
    drop_cnt_d = (reject && (drop_base != 15'h7FFF)) ? drop_base + 15'd1 : drop_base;
    in_frame_d = kp.i_end ? 1'b0 : frame_act;
    hs         = valid_q && kp.i_ready;

    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    desc_d    = desc_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    trail_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_cnt_q != '0) begin
          state_d = S_HDR;
          data_d  = make_hdr(head_rec);
          desc_d  = head_rec[DESC_W-1:0];
          valid_d = 1'b1;
          last_d  = 1'b0;
        end else if (trail_pend_q) begin
          state_d = S_TRAIL;
          data_d  = trail_word;
          valid_d = 1'b1;
          last_d  = 1'b1;
        end
      end
      S_HDR: begin
        if (hs) begin
          state_d = S_DESC;
          data_d  = desc_q[DESC_W-1 -: OUT_W];
          desc_d  = desc_q << OUT_W;
          idx_d   = '0;
          last_d  = (NW == 1);
        end
      end
      S_DESC: begin
        if (hs) begin
          if (idx_q == IDX_W'(NW - 1)) begin
            pop = 1'b1;
            if (fifo_cnt_q > (AW + 1)'(1)) begin
              state_d = S_HDR;
              data_d  = make_hdr(next_rec);
              desc_d  = next_rec[DESC_W-1:0];
              last_d  = 1'b0;
            end else if (trail_pend_q && !push) begin
              state_d = S_TRAIL;
              data_d  = trail_word;
              last_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = desc_q[DESC_W-1 -: OUT_W];
            desc_d = desc_q << OUT_W;
            last_d = (idx_q == IDX_W'(NW - 2));
          end
        end
      end
      S_TRAIL: begin
        if (hs) begin
          state_d   = S_IDLE;
          valid_d   = 1'b0;
          last_d    = 1'b0;
          trail_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A trailer handed off this cycle frees the slot for a same-cycle i_end
    trail_free   = !trail_pend_q || trail_clr;
    trail_pend_d = trail_pend_q && !trail_clr;
    trail_kp_d   = trail_kp_q;
    trail_drop_d = trail_drop_q;
    ovf_d        = (kp.i_start ? 1'b0 : ovf_q) | reject;
    if (kp.i_end && frame_act) begin
      if (trail_free) begin
        trail_pend_d = 1'b1;
        trail_kp_d   = kp_cnt_d;
        trail_drop_d = drop_cnt_d;
      end else begin
        ovf_d = 1'b1;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Record memory write port (no reset so it maps onto RAM)
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {kp.i_x, kp.i_y, kp.i_score, kp.i_desc};
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      in_frame_q   <= 1'b0;
      kp_cnt_q     <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      trail_pend_q <= 1'b0;
      trail_kp_q   <= '0;
      trail_drop_q <= '0;
      state_q      <= S_IDLE;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      desc_q       <= '0;
      idx_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      in_frame_q   <= in_frame_d;
      kp_cnt_q     <= kp_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
      trail_pend_q <= trail_pend_d;
      trail_kp_q   <= trail_kp_d;
      trail_drop_q <= trail_drop_d;
      state_q      <= state_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      desc_q       <= desc_d;
      idx_q        <= idx_d;
    end
  end

  assign kp.o_data       = data_q;
  assign kp.o_valid      = valid_q;
  assign kp.o_last       = last_q;
  assign kp.o_overflow   = ovf_q;
  assign kp.o_kp_count   = kp_cnt_q;
  assign kp.o_drop_count = drop_cnt_q;
endmodule
